// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters.
// One operation is in flight at a time; the result returns as a one-cycle pulse.
module alu_arbiter #(
    parameter int ALU_LAT = 1,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_sr1,
    input  logic [W-1:0] req0_sr2,
    input  logic [2:0]   req0_os,
    input  logic [W-1:0] req0_shift,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_sr1,
    input  logic [W-1:0] req1_sr2,
    input  logic [2:0]   req1_os,
    input  logic [W-1:0] req1_shift,

    output logic         resp0_valid,
    output logic         resp1_valid,
    output logic [W-1:0] resp_rd,
    output logic         resp_zero,
    output logic         busy,

    output logic [W-1:0] alu_sr1,
    output logic [W-1:0] alu_sr2,
    output logic [2:0]   alu_os,
    output logic [W-1:0] alu_shift,
    input  logic [W-1:0] alu_rd,
    input  logic         alu_zero
);

    localparam int CW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_last_grant;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_alu_sr1;
    logic [W-1:0]  r_alu_sr2;
    logic [2:0]    r_alu_os;
    logic [W-1:0]  r_alu_shift;
    logic [W-1:0]  r_resp_rd;
    logic          r_resp_zero;

    logic          w_idle;
    logic          w_grant;
    logic          w_accept;

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        w_idle   = (r_state == IDLE);
        w_grant  = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
        w_accept = w_idle && (req0_valid || req1_valid);
    end

    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept &&  w_grant;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_alu_sr1    <= '0;
            r_alu_sr2    <= '0;
            r_alu_os     <= '0;
            r_alu_shift  <= '0;
            r_resp_rd    <= '0;
            r_resp_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_sr1    <= w_grant ? req1_sr1   : req0_sr1;
                        r_alu_sr2    <= w_grant ? req1_sr2   : req0_sr2;
                        r_alu_os     <= w_grant ? req1_os    : req0_os;
                        r_alu_shift  <= w_grant ? req1_shift : req0_shift;
                        r_last_grant <= w_grant;
                        r_cnt        <= CW'(ALU_LAT);
                        r_state      <= BUSY;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_resp_rd   <= alu_rd;
                        r_resp_zero <= alu_zero;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The pulse is masked by reset so an operation cut off in its RESP cycle never reports.
    assign resp0_valid = (r_state == RESP) && !r_last_grant && !reset;
    assign resp1_valid = (r_state == RESP) &&  r_last_grant && !reset;

    assign resp_rd   = r_resp_rd;
    assign resp_zero = r_resp_zero;
    assign busy      = (r_state != IDLE);
    assign alu_sr1   = r_alu_sr1;
    assign alu_sr2   = r_alu_sr2;
    assign alu_os    = r_alu_os;
    assign alu_shift = r_alu_shift;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU_LAT=1 and ALU_LAT=4 instances on shared stimulus,
// checked against a timeline model plus directed scenario checks.
module tb_alu_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]   v;
    logic [W-1:0] s1 [2];
    logic [W-1:0] s2 [2];
    logic [2:0]   os [2];
    logic [W-1:0] sh [2];

    logic [1:0]   rdy0, rdy1, rv0, rv1, bsy, rz, az;
    logic [W-1:0] rrd  [2];
    logic [W-1:0] asr1 [2];
    logic [W-1:0] asr2 [2];
    logic [2:0]   aos  [2];
    logic [W-1:0] ash  [2];
    logic [W-1:0] ard  [2];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int lat [2] = '{1, 4};

    // ALU stub, combinational on the arbiter's registered operands
    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op, input logic [W-1:0] s);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << s[4:0];
            3'd6:    return a >> s[4:0];
            default: return (a < b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    assign ard[0] = alu_f(asr1[0], asr2[0], aos[0], ash[0]);
    assign ard[1] = alu_f(asr1[1], asr2[1], aos[1], ash[1]);
    assign az[0]  = (ard[0] == '0);
    assign az[1]  = (ard[1] == '0);

    alu_arbiter #(.ALU_LAT(1), .W(W)) u_lat1 (
        .clk(clk), .reset(reset),
        .req0_valid(v[0]), .req0_ready(rdy0[0]), .req0_sr1(s1[0]), .req0_sr2(s2[0]),
        .req0_os(os[0]), .req0_shift(sh[0]),
        .req1_valid(v[1]), .req1_ready(rdy1[0]), .req1_sr1(s1[1]), .req1_sr2(s2[1]),
        .req1_os(os[1]), .req1_shift(sh[1]),
        .resp0_valid(rv0[0]), .resp1_valid(rv1[0]), .resp_rd(rrd[0]), .resp_zero(rz[0]),
        .busy(bsy[0]), .alu_sr1(asr1[0]), .alu_sr2(asr2[0]), .alu_os(aos[0]),
        .alu_shift(ash[0]), .alu_rd(ard[0]), .alu_zero(az[0])
    );

    alu_arbiter #(.ALU_LAT(4), .W(W)) u_lat4 (
        .clk(clk), .reset(reset),
        .req0_valid(v[0]), .req0_ready(rdy0[1]), .req0_sr1(s1[0]), .req0_sr2(s2[0]),
        .req0_os(os[0]), .req0_shift(sh[0]),
        .req1_valid(v[1]), .req1_ready(rdy1[1]), .req1_sr1(s1[1]), .req1_sr2(s2[1]),
        .req1_os(os[1]), .req1_shift(sh[1]),
        .resp0_valid(rv0[1]), .resp1_valid(rv1[1]), .resp_rd(rrd[1]), .resp_zero(rz[1]),
        .busy(bsy[1]), .alu_sr1(asr1[1]), .alu_sr2(asr2[1]), .alu_os(aos[1]),
        .alu_shift(ash[1]), .alu_rd(ard[1]), .alu_zero(az[1])
    );

    // Timeline model: an accept at cycle t answers at t+LAT+1 and frees the ALU at t+LAT+2.
    int           m_free     [2];
    int           m_resp_cyc [2];
    int           m_port     [2];
    int           m_last     [2];
    logic [W-1:0] m_pend     [2];
    logic [W-1:0] m_rd       [2];
    logic         m_zero     [2];
    logic [98:0]  m_alu      [2];

    task automatic step();
        logic        idle;
        int          g;
        logic [4:0]  exp_ctrl;
        logic [4:0]  got_ctrl;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                n_total++;
                if ({rv0[k], rv1[k]} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL resp_during_reset inst=%0d cyc=%0d got=%b exp=00", k, cyc, {rv0[k], rv1[k]});
                end
                m_free[k] = cyc + 1; m_resp_cyc[k] = -1; m_last[k] = 1; m_port[k] = 0;
                m_rd[k] = '0; m_zero[k] = 1'b0; m_alu[k] = '0;
            end else begin
                if (cyc == m_resp_cyc[k]) begin
                    m_rd[k]   = m_pend[k];
                    m_zero[k] = (m_pend[k] == '0);
                end
                idle = (cyc >= m_free[k]);
                g = (v == 2'b11) ? 1 - m_last[k] : (v[1] ? 1 : 0);
                exp_ctrl = {idle && v[0] && g == 0, idle && v[1] && g == 1, !idle,
                            cyc == m_resp_cyc[k] && m_port[k] == 0,
                            cyc == m_resp_cyc[k] && m_port[k] == 1};
                got_ctrl = {rdy0[k], rdy1[k], bsy[k], rv0[k], rv1[k]};
                n_total++;
                if (got_ctrl !== exp_ctrl) begin
                    n_bad++;
                    $display("FAIL ctrl{rdy0,rdy1,busy,rv0,rv1} inst=%0d cyc=%0d got=%b exp=%b", k, cyc, got_ctrl, exp_ctrl);
                end
                n_total++;
                if ({rz[k], rrd[k]} !== {m_zero[k], m_rd[k]}) begin
                    n_bad++;
                    $display("FAIL resp_data inst=%0d cyc=%0d got=%b/%0h exp=%b/%0h", k, cyc, rz[k], rrd[k], m_zero[k], m_rd[k]);
                end
                n_total++;
                if ({asr1[k], asr2[k], aos[k], ash[k]} !== m_alu[k]) begin
                    n_bad++;
                    $display("FAIL alu_regs inst=%0d cyc=%0d got=%h exp=%h", k, cyc, {asr1[k], asr2[k], aos[k], ash[k]}, m_alu[k]);
                end
                if (idle && v != 2'b00) begin
                    m_last[k]     = g;
                    m_port[k]     = g;
                    m_resp_cyc[k] = cyc + lat[k] + 1;
                    m_free[k]     = cyc + lat[k] + 2;
                    m_pend[k]     = alu_f(s1[g], s2[g], os[g], sh[g]);
                    m_alu[k]      = {s1[g], s2[g], os[g], sh[g]};
                end
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] op, input logic [W-1:0] s);
        s1[p] = a; s2[p] = b; os[p] = op; sh[p] = s;
    endtask

    task automatic apply_reset();
        reset = 1'b1; v = 2'b00;
        #1; step(); #1; step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({bsy[k], rv0[k], rv1[k], rz[k], rrd[k], asr1[k], aos[k]} !== '0) begin
                n_bad++;
                $display("FAIL reset_state inst=%0d got busy=%b rv=%b%b z=%b rd=%0h sr1=%0h os=%0h exp all zero",
                         k, bsy[k], rv0[k], rv1[k], rz[k], rrd[k], asr1[k], aos[k]);
            end
        end
        step();
    endtask

    task automatic test_single_port0();
        apply_reset();
        set_port(0, 32'd9, 32'd1, 3'd0, 32'd0);
        v = 2'b01; #1;
        n_total++;
        if (rdy0[0] !== 1'b1) begin n_bad++; $display("FAIL single0_ready got=%b exp=1", rdy0[0]); end
        step();
        v = 2'b00; #1;
        n_total++;
        if (asr1[0] !== 32'd9) begin n_bad++; $display("FAIL single0_alu_sr1 got=%0d exp=9", asr1[0]); end
        step(); #1;
        n_total++;
        if ({rv0[0], rv1[0], rz[0], rrd[0]} !== {1'b1, 1'b0, 1'b0, 32'd10}) begin
            n_bad++;
            $display("FAIL single0_resp got rv0=%b rv1=%b z=%b rd=%0d exp 1 0 0 10", rv0[0], rv1[0], rz[0], rrd[0]);
        end
        for (int i = 0; i < 6; i++) begin
            step(); #1;
            n_total++;
            if (rv1[0] !== 1'b0) begin n_bad++; $display("FAIL single0_no_resp1 got=%b exp=0", rv1[0]); end
        end
        step();
    endtask

    task automatic test_zero_port1();
        apply_reset();
        set_port(1, 32'd5, 32'd5, 3'd1, 32'd0);
        v = 2'b10; #1;
        n_total++;
        if (rdy1[0] !== 1'b1) begin n_bad++; $display("FAIL zero1_ready got=%b exp=1", rdy1[0]); end
        step();
        v = 2'b00; #1;
        step(); #1;
        n_total++;
        if ({rv1[0], rv0[0], rz[0], rrd[0]} !== {1'b1, 1'b0, 1'b1, 32'd0}) begin
            n_bad++;
            $display("FAIL zero1_resp got rv1=%b rv0=%b z=%b rd=%0d exp 1 0 1 0", rv1[0], rv0[0], rz[0], rrd[0]);
        end
        for (int i = 0; i < 6; i++) begin #1; step(); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        set_port(0, 32'd100, 32'd7, 3'd0, 32'd0);
        set_port(1, 32'd20, 32'd3, 3'd0, 32'd0);
        v = 2'b11;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_total++;
            if ({rdy0[0], rdy1[0]} !== {i % 6 == 0, i % 6 == 3}) begin
                n_bad++;
                $display("FAIL b2b_grant i=%0d got=%b%b exp=%b%b", i, rdy0[0], rdy1[0], i % 6 == 0, i % 6 == 3);
            end
            if (i % 6 == 2) begin
                n_total++;
                if ({rv0[0], rv1[0], rrd[0]} !== {2'b10, 32'd107}) begin
                    n_bad++;
                    $display("FAIL b2b_resp0 i=%0d got rv=%b%b rd=%0d exp 10 107", i, rv0[0], rv1[0], rrd[0]);
                end
            end
            if (i % 6 == 5) begin
                n_total++;
                if ({rv0[0], rv1[0], rrd[0]} !== {2'b01, 32'd23}) begin
                    n_bad++;
                    $display("FAIL b2b_resp1 i=%0d got rv=%b%b rd=%0d exp 01 23", i, rv0[0], rv1[0], rrd[0]);
                end
            end
            step();
        end
        v = 2'b00;
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        set_port(0, 32'd9, 32'd1, 3'd0, 32'd0);
        v = 2'b01; #1;
        step();
        v = 2'b00; reset = 1'b1; #1;
        n_total++;
        if (rv0[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_no_pulse_busy got=%b exp=0", rv0[0]); end
        step();
        reset = 1'b0;
        set_port(0, 32'd30, 32'd12, 3'd0, 32'd0);
        set_port(1, 32'd1, 32'd1, 3'd0, 32'd0);
        v = 2'b11; #1;
        n_total++;
        if ({bsy[0], asr1[0], rv0[0]} !== '0) begin
            n_bad++;
            $display("FAIL midrst_cleared got busy=%b sr1=%0d rv0=%b exp 0 0 0", bsy[0], asr1[0], rv0[0]);
        end
        n_total++;
        if ({rdy0[0], rdy1[0]} !== 2'b10) begin
            n_bad++;
            $display("FAIL midrst_tie got=%b%b exp=10", rdy0[0], rdy1[0]);
        end
        step();
        v = 2'b00; #1;
        step(); #1;
        n_total++;
        if ({rv0[0], rrd[0]} !== {1'b1, 32'd42}) begin
            n_bad++;
            $display("FAIL midrst_resp got rv0=%b rd=%0d exp 1 42", rv0[0], rrd[0]);
        end
        step();
    endtask

    task automatic test_lat4();
        apply_reset();
        set_port(0, 32'd9, 32'd1, 3'd0, 32'd0);
        set_port(1, 32'd3, 32'd4, 3'd0, 32'd0);
        v = 2'b01; #1;
        n_total++;
        if (rdy0[1] !== 1'b1) begin n_bad++; $display("FAIL lat4_ready0 got=%b exp=1", rdy0[1]); end
        step();
        v = 2'b00; #1;
        step();
        v = 2'b10;
        for (int i = 2; i <= 6; i++) begin
            #1;
            if (i == 4 || i == 5) begin
                n_total++;
                if (rv0[1] !== (i == 5)) begin
                    n_bad++;
                    $display("FAIL lat4_resp0_timing i=%0d got=%b exp=%b", i, rv0[1], i == 5);
                end
            end
            if (i == 5) begin
                n_total++;
                if (rrd[1] !== 32'd10) begin n_bad++; $display("FAIL lat4_rd got=%0d exp=10", rrd[1]); end
            end
            n_total++;
            if (rdy1[1] !== (i == 6)) begin
                n_bad++;
                $display("FAIL lat4_ready1 i=%0d got=%b exp=%b", i, rdy1[1], i == 6);
            end
            step();
            // Port 1 drops only once the LAT=4 instance has granted it.
            if (i == 6) v = 2'b00;
        end
        for (int i = 0; i < 8; i++) begin #1; step(); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            v = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                set_port(p, $urandom_range(0, 3) == 0 ? s2[p] : $urandom(), $urandom_range(0, 15),
                         3'($urandom_range(0, 7)), $urandom());
            end
            reset = ($urandom_range(0, 49) == 0);
            #1;
            step();
        end
        reset = 1'b0; v = 2'b00;
        for (int i = 0; i < 8; i++) begin #1; step(); end
    endtask

    initial begin
        reset = 1'b1;
        v = 2'b00;
        for (int p = 0; p < 2; p++) set_port(p, '0, '0, 3'd0, '0);
        @(negedge clk);
        test_reset();
        test_single_port0();
        test_zero_port1();
        test_back_to_back();
        test_reset_mid_op();
        test_lat4();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single registered ALU (sr1, sr2, os, shift in; rd, zeroflag out) between two requesters, e.g. the execute stage (port 0) and the address/branch unit (port 1).
- Accepts one operation at a time through a valid/ready handshake and arbitrates round-robin.
- Drives the ALU operand/opcode inputs from registers, waits the ALU latency, then returns the captured rd/zeroflag to the granted requester as a one-cycle response pulse.

Parameters:
- ALU_LAT, 1, cycles from ALU inputs stable to rd/zeroflag valid (1..15).
- W, 32, operand/result width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_sr1, req0_sr2  in  W  requester 0 operands.
- req0_os  in  3  requester 0 ALU opcode.
- req0_shift  in  W  requester 0 shift amount.
- req1_valid, req1_ready, req1_sr1, req1_sr2, req1_os, req1_shift: same as port 0, for requester 1.
- resp0_valid  out  1  result for requester 0, one-cycle pulse.
- resp1_valid  out  1  result for requester 1, one-cycle pulse.
- resp_rd  out  W  captured ALU result (shared by both responses).
- resp_zero  out  1  captured ALU zeroflag.
- busy  out  1  high whenever state != IDLE.
- alu_sr1, alu_sr2  out  W  to ALU sr1/sr2.
- alu_os  out  3  to ALU os.
- alu_shift  out  W  to ALU shift.
- alu_rd  in  W  from ALU rd.
- alu_zero  in  1  from ALU zeroflag.

Behaviour:
- Reset values (reset high at an edge):
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - All alu_* outputs = 0; resp_rd = 0; resp_zero = 0.
  - resp0_valid = resp1_valid = 0; busy = 0; wait counter = 0.
- States: IDLE -> BUSY -> RESP -> IDLE.
- Ready is combinational: reqN_ready = (state == IDLE) && grant == N && reqN_valid. No ready is asserted outside IDLE.
- Arbitration in IDLE:
  - Only one valid: that port is granted.
  - Both valid: the port != last_grant is granted.
  - Neither valid: stay in IDLE.
- Accept, cycle T (handshake):
  - Latch the granted port's sr1/sr2/os/shift into the alu_* registers.
  - last_grant <= N; counter <= ALU_LAT; state <= BUSY.
- BUSY, cycles T+1 .. T+ALU_LAT:
  - alu_* held stable.
  - Counter decrements each cycle. In the cycle where counter == 1, resp_rd <= alu_rd, resp_zero <= alu_zero, state <= RESP.
- RESP, cycle T+ALU_LAT+1:
  - respN_valid = 1 for the granted N only.
  - resp_rd/resp_zero held; state <= IDLE.
- alu_* keep their last value in IDLE (no toggling). resp_rd/resp_zero hold until the next capture.
- Latency and throughput:
  - Accept to response = ALU_LAT+1 cycles.
  - Back-to-back accepts are ALU_LAT+2 cycles apart.
  - ALU_LAT=1: accept T, response T+2, next accept T+3.
- Requester rule: valid and operands must stay stable until ready. The arbiter does not check this. A port whose valid drops before grant is simply not served.
- Responses have no backpressure: the requester must take the pulse.
- Starvation-free: with both ports always valid, grants strictly alternate 0,1,0,1.
- Reset mid-operation (BUSY or RESP):
  - Operation is dropped; no resp pulse is issued, even if reset lands in the RESP cycle.
  - All outputs return to reset values at that edge.
- Requests asserted while busy wait in IDLE for arbitration. A request arriving in the RESP cycle is considered in the following IDLE cycle.

Test Plan:
- The bench uses an ALU stub with ALU_LAT=1: os=000 gives rd=sr1+sr2, os=001 gives rd=sr1-sr2; zeroflag=(rd==0).
- Single op, port 0: sr1=9, sr2=1, os=000, valid at T -> req0_ready at T; alu_sr1=9 from T+1; resp0_valid at T+2 with resp_rd=10, resp_zero=0; resp1_valid never set.
- Zero result, port 1: sr1=5, sr2=5, os=001 -> resp1_valid after 2 cycles, resp_rd=0, resp_zero=1.
- Both valid every cycle, after reset -> grant order 0,1,0,1; accepts 3 cycles apart; each resp pulse goes to the matching port with the correct sum.
- Reset asserted in BUSY cycle T+1 -> no resp pulse; busy=0 and alu_sr1=0 next cycle; a later request completes normally with port 0 winning a tie.
- ALU_LAT=4 instance, sr1=9, sr2=1, os=000 -> req0_ready at T, resp0_valid exactly at T+5 with resp_rd=10; req1 arriving at T+2 is granted at T+6.
